card_deck: RTL and testbench

- Upstream card source for the blackjack game FSM; replaces fixed card constants with real draws from a 52-card deck.
- On each draw request, picks a not-yet-dealt card pseudo-randomly and returns its value (1..13) and suit (0..3).
- Tracks dealt cards in a 52-bit mask so no card repeats until the next shuffle.
- Output is held stable after delivery so the frame-rate game FSM can sample it at any later cycle.

---
 rtl/card_deck.sv | 157 +++++++++++++++
 tb/tb_card_deck.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/card_deck.sv
// 52-card deck: deals undealt cards chosen by a 16-bit Galois LFSR with rejection sampling and linear probing.
// Optional macro CARD_DECK_ORDERED_EN deals in fixed order from a sequential counter instead.
module card_deck #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shuffle,
  input  logic       draw_req,
  output logic       card_valid,
  output logic [3:0] card_value,
  output logic [1:0] card_symbol,
  output logic       busy,
  output logic [5:0] cards_left,
  output logic       deck_empty,
  output logic       empty_err,
  output logic [1:0] dbg_state
);

  // Handshake: draw_req is sampled only while IDLE (busy low); card_valid is a
  // one-cycle pulse and card_value/card_symbol hold until the next delivery.

  typedef enum logic [1:0] {IDLE = 2'd0, GEN = 2'd1, PROBE = 2'd2, DELIVER = 2'd3} state_t;

  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] TAPS = 16'hB400;
  localparam logic [5:0]  DECK = 6'd52;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [51:0] used_q, used_d;
  logic [5:0]  idx_q, idx_d;
  logic [5:0]  left_q, left_d;
  logic [3:0]  value_q, value_d;
  logic [1:0]  symbol_q, symbol_d;
  logic        err_q, err_d;
  logic [1:0]  sym_w;
  logic [5:0]  rem_w;
  logic [3:0]  val_w;
`ifdef CARD_DECK_ORDERED_EN
  logic [5:0]  ord_q, ord_d;
`endif

  // idx -> (suit, value) by subtracting whole suits; no divider needed.
  always_comb begin
    sym_w = 2'd0;
    rem_w = idx_q;
    if (idx_q >= 6'd39) begin
      sym_w = 2'd3;
      rem_w = idx_q - 6'd39;
    end else if (idx_q >= 6'd26) begin
      sym_w = 2'd2;
      rem_w = idx_q - 6'd26;
    end else if (idx_q >= 6'd13) begin
      sym_w = 2'd1;
      rem_w = idx_q - 6'd13;
    end
    val_w = rem_w[3:0] + 4'd1;
  end

  always_comb begin
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    state_d  = state_q;
    used_d   = used_q;
    idx_d    = idx_q;
    left_d   = left_q;
    value_d  = value_q;
    symbol_d = symbol_q;
    err_d    = 1'b0;
`ifdef CARD_DECK_ORDERED_EN
    ord_d    = ord_q;
`endif
    if (shuffle) begin
      // Shuffle wins in every state and aborts any draw before its used bit is set.
      state_d = IDLE;
      used_d  = '0;
      left_d  = DECK;
`ifdef CARD_DECK_ORDERED_EN
      ord_d   = 6'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (draw_req) begin
            if (left_q == 6'd0) err_d = 1'b1;
            else                state_d = GEN;
          end
        end
        GEN: begin
`ifdef CARD_DECK_ORDERED_EN
          idx_d   = ord_q;
          state_d = PROBE;
`else
          if (lfsr_q[5:0] < DECK) begin
            idx_d   = lfsr_q[5:0];
            state_d = PROBE;
          end
`endif
        end
        PROBE: begin
          if (used_q[idx_q]) begin
            idx_d = (idx_q == 6'd51) ? 6'd0 : idx_q + 6'd1;
          end else begin
            used_d[idx_q] = 1'b1;
            left_d        = left_q - 6'd1;
            value_d       = val_w;
            symbol_d      = sym_w;
`ifdef CARD_DECK_ORDERED_EN
            ord_d         = ord_q + 6'd1;
`endif
            state_d       = DELIVER;
          end
        end
        DELIVER: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      used_q   <= '0;
      idx_q    <= 6'd0;
      left_q   <= DECK;
      value_q  <= 4'd0;
      symbol_q <= 2'd0;
      err_q    <= 1'b0;
`ifdef CARD_DECK_ORDERED_EN
      ord_q    <= 6'd0;
`endif
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      used_q   <= used_d;
      idx_q    <= idx_d;
      left_q   <= left_d;
      value_q  <= value_d;
      symbol_q <= symbol_d;
      err_q    <= err_d;
`ifdef CARD_DECK_ORDERED_EN
      ord_q    <= ord_d;
`endif
    end
  end

  assign card_valid  = (state_q == DELIVER);
  assign card_value  = value_q;
  assign card_symbol = symbol_q;
  assign busy        = (state_q != IDLE);
  assign cards_left  = left_q;
  assign deck_empty  = (left_q == 6'd0);
  assign empty_err   = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_card_deck.sv
// Directed bench for card_deck; exact deal-order checks apply when CARD_DECK_ORDERED_EN is defined.
module tb_card_deck;

  logic       clk;
  logic       rst_n;
  logic       shuffle;
  logic       draw_req;
  logic       card_valid;
  logic [3:0] card_value;
  logic [1:0] card_symbol;
  logic       busy;
  logic [5:0] cards_left;
  logic       deck_empty;
  logic       empty_err;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int deal_k   = 0;

  card_deck dut (
    .clk         (clk),
    .rst         (rst_n),
    .shuffle     (shuffle),
    .draw_req    (draw_req),
    .card_valid  (card_valid),
    .card_value  (card_value),
    .card_symbol (card_symbol),
    .busy        (busy),
    .cards_left  (cards_left),
    .deck_empty  (deck_empty),
    .empty_err   (empty_err),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one draw_req and wait (bounded) for card_valid, sampling on negedges.
  task automatic do_draw(output logic [3:0] v, output logic [1:0] s, output int lat,
                         output bit busy_all);
    bit got;
    got      = 1'b0;
    busy_all = 1'b1;
    @(negedge clk);
    draw_req = 1'b1;
    @(negedge clk);
    draw_req = 1'b0;
    lat = 1;
    while (!got && lat < 200) begin
      busy_all = busy_all & busy;
      if (card_valid) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check_eq("draw_completes", got, 1);
    v = card_value;
    s = card_symbol;
  endtask

  // Deal a full deck: every card in range, distinct, latency bounded.
  task automatic deal_all(input string phase);
    bit [51:0] seen;
    logic [3:0] v;
    logic [1:0] s;
    int lat;
    int key;
    bit ba;
    seen   = '0;
    deal_k = 0;
    for (int k = 0; k < 52; k++) begin
      do_draw(v, s, lat, ba);
      check_eq({phase, "_value_range"}, (v >= 4'd1 && v <= 4'd13), 1);
      key = int'(s) * 13 + int'(v) - 1;
      if (key >= 0 && key < 52) begin
        check_eq({phase, "_distinct"}, seen[key], 0);
        seen[key] = 1'b1;
      end
      check_eq({phase, "_latency_bound"}, (lat >= 3 && lat <= 117), 1);
      check_eq({phase, "_busy_during_draw"}, ba, 1);
`ifdef CARD_DECK_ORDERED_EN
      check_eq({phase, "_ord_value"}, v, (k % 13) + 1);
      check_eq({phase, "_ord_symbol"}, s, k / 13);
      check_eq({phase, "_ord_latency"}, lat, 3);
`endif
      if (k == 0)  check_eq({phase, "_left_after_1"}, cards_left, 51);
      if (k == 13) check_eq({phase, "_left_after_14"}, cards_left, 38);
    end
    check_eq({phase, "_all_cards_seen"}, seen, 52'hF_FFFF_FFFF_FFFF);
  endtask

  initial begin
    logic [3:0] v;
    logic [1:0] s;
    int lat;
    bit ba;
    bit saw;
    int n;

    rst_n    = 1'b0;
    shuffle  = 1'b0;
    draw_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    check_eq("rst_card_valid", card_valid, 0);
    check_eq("rst_card_value", card_value, 0);
    check_eq("rst_card_symbol", card_symbol, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cards_left", cards_left, 52);
    check_eq("rst_deck_empty", deck_empty, 0);
    check_eq("rst_empty_err", empty_err, 0);

    // full deal from a fresh deck
    deal_all("deal1");
    @(negedge clk);
    check_eq("idle_after_deal_busy", busy, 0);
    check_eq("empty_cards_left", cards_left, 0);
    check_eq("empty_deck_empty", deck_empty, 1);

    // 53rd request: empty_err pulse, no delivery
    draw_req = 1'b1;
    @(negedge clk);
    draw_req = 1'b0;
    check_eq("empty_err_pulse", empty_err, 1);
    check_eq("empty_no_valid", card_valid, 0);
    check_eq("empty_not_busy", busy, 0);
    @(negedge clk);
    check_eq("empty_err_one_cycle", empty_err, 0);
    check_eq("empty_still_no_valid", card_valid, 0);
`ifdef CARD_DECK_ORDERED_EN
    check_eq("empty_hold_value", card_value, 13);
    check_eq("empty_hold_symbol", card_symbol, 3);
`endif

    // shuffle restores the deck
    shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    check_eq("shuffle_cards_left", cards_left, 52);
    check_eq("shuffle_deck_empty", deck_empty, 0);

    for (int k = 0; k < 5; k++) begin
      do_draw(v, s, lat, ba);
      check_eq("pre_abort_range", (v >= 4'd1 && v <= 4'd13), 1);
`ifdef CARD_DECK_ORDERED_EN
      check_eq("pre_abort_ord_value", v, k + 1);
`endif
    end
    check_eq("pre_abort_left", cards_left, 47);

    // sixth draw aborted by shuffle while in PROBE
    @(negedge clk);
    draw_req = 1'b1;
    @(negedge clk);
    draw_req = 1'b0;
    n = 0;
    while (dbg_state != 2'd2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("abort_reached_probe", dbg_state, 2);
    shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    check_eq("abort_idle", busy, 0);
    check_eq("abort_cards_left", cards_left, 52);
    saw = card_valid;
    repeat (5) begin
      @(negedge clk);
      saw = saw | card_valid;
    end
    check_eq("abort_no_valid", saw, 0);
`ifdef CARD_DECK_ORDERED_EN
    check_eq("abort_hold_value", card_value, 5);
    check_eq("abort_hold_symbol", card_symbol, 0);
`endif

    deal_all("deal2");

    // reset asserted during GEN
    shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    draw_req = 1'b1;
    @(negedge clk);
    draw_req = 1'b0;
    check_eq("pre_reset_in_gen", dbg_state, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_valid", card_valid, 0);
    check_eq("async_rst_value", card_value, 0);
    check_eq("async_rst_symbol", card_symbol, 0);
    check_eq("async_rst_left", cards_left, 52);
    check_eq("async_rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_draw(v, s, lat, ba);
    check_eq("post_rst_range", (v >= 4'd1 && v <= 4'd13), 1);
    check_eq("post_rst_left", cards_left, 51);
    check_eq("post_rst_latency", (lat >= 3 && lat <= 117), 1);
`ifdef CARD_DECK_ORDERED_EN
    check_eq("post_rst_ord_value", v, 1);
    check_eq("post_rst_ord_symbol", s, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
